// File: rtl/cdc_handshake_tx.sv
// Sending side of a four-phase req/ack clock-domain-crossing handshake.
// Optional ack timeout abort enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_async
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK_HI,
        WAIT_ACK_LO
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SYNC_STAGES-1:0]  ack_chain;
    logic                    ack_sync;
    logic                    timed_out;
    logic                    req_next;
    logic                    done_next;
    logic                    err_next;
    logic [DATA_WIDTH-1:0]   data_next;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_handshake_tx: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("cdc_handshake_tx: TIMEOUT_CYCLES must be >= 2");
    end

    // ack_async is only ever observed through this chain
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ack_chain <= '0;
        end else begin
            ack_chain <= {ack_chain[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign ack_sync = ack_chain[SYNC_STAGES-1];
    assign ready    = (state == IDLE) && !ack_sync;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] wait_count;

    // Counts cycles spent in the current wait state; any state change restarts it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_count <= '0;
        end else if (state_next != state) begin
            wait_count <= '0;
        end else if (state != IDLE) begin
            wait_count <= wait_count + CW'(1);
        end
    end

    assign timed_out = (wait_count == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_next = state;
        req_next   = req_out;
        data_next  = data_out;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (send && ready) begin
                    data_next  = data_in;
                    req_next   = 1'b1;
                    state_next = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (ack_sync) begin
                    req_next   = 1'b0;
                    state_next = WAIT_ACK_LO;
                end else if (timed_out) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_sync) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (timed_out) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // data_out and req_out move on the same edge so the word is settled
    // well before the remote side sees the synchronized request
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            req_out  <= req_next;
            data_out <= data_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Randomized self-checking bench for cdc_handshake_tx with a remote-side ack model
// and a transaction-level reference model driven by a delayed view of ack_async.
module tb_cdc_handshake_tx;

    localparam int DW      = 8;
    localparam int SS      = 2;
    localparam int TIMEOUT = 16;
`ifdef CDC_TX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          n_rst;
    logic          send;
    logic [DW-1:0] data_in;
    logic          ready;
    logic          done;
    logic          err;
    logic          req_out;
    logic [DW-1:0] data_out;
    logic          ack_async;

    int checks = 0;
    int errors = 0;

    int remote_mode  = 0;
    int remote_delay = 4;
    int rcnt         = 0;

    int            phase;
    int            edge_no;
    int            entry_edge;
    bit            hist[$];
    bit            sync_now;
    logic [DW-1:0] exp_data;
    logic          exp_req;
    logic          exp_done;
    logic          exp_err;
    logic          exp_ready;

    cdc_handshake_tx #(
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .send     (send),
        .data_in  (data_in),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_async(ack_async)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [DW-1:0] d);
        @(negedge clk);
        send    = s;
        data_in = d;
    endtask

    task automatic waitReady(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 300);
        checkOutput(tag, {31'd0, ready}, 32'd1);
    endtask

    // Remote domain: mirrors req_out onto ack_async after remote_delay cycles
    initial begin
        ack_async = 1'b0;
        forever begin
            @(negedge clk);
            case (remote_mode)
                1: ack_async = 1'b1;
                2: ack_async = 1'b0;
                default: begin
                    if (req_out != ack_async) begin
                        rcnt++;
                        if (rcnt >= remote_delay) begin
                            ack_async = req_out;
                            rcnt      = 0;
                        end
                    end else begin
                        rcnt = 0;
                    end
                end
            endcase
        end
    end

    // Reference model: the block sees ack_async SS edges late; one transfer
    // is in flight at a time, tracked by phase and the edge it began waiting on
    initial begin
        phase = 0; edge_no = 0; entry_edge = 0;
        exp_data = '0; exp_req = 0; exp_done = 0; exp_err = 0; exp_ready = 1;
        for (int i = 0; i < SS; i++) hist.push_back(1'b0);
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                phase = 0;
                exp_data = '0; exp_req = 0; exp_done = 0; exp_err = 0; exp_ready = 1;
                hist.delete();
                for (int i = 0; i < SS; i++) hist.push_back(1'b0);
            end else begin
                sync_now = hist[0];
                edge_no++;
                exp_done = 0;
                exp_err  = 0;
                if (phase == 0) begin
                    if (send && !sync_now) begin
                        exp_data   = data_in;
                        phase      = 1;
                        entry_edge = edge_no;
                    end
                end else if (phase == 1) begin
                    if (sync_now) begin
                        phase      = 2;
                        entry_edge = edge_no;
                    end else if (TO_EN && (edge_no - entry_edge == TIMEOUT)) begin
                        phase   = 0;
                        exp_err = 1;
                    end
                end else begin
                    if (!sync_now) begin
                        phase    = 0;
                        exp_done = 1;
                    end else if (TO_EN && (edge_no - entry_edge == TIMEOUT)) begin
                        phase   = 0;
                        exp_err = 1;
                    end
                end
                hist.delete(0);
                hist.push_back(ack_async);
                exp_req   = (phase == 1);
                exp_ready = (phase == 0) && !hist[0];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1) begin
                checkOutput("req",   {31'd0, req_out}, {31'd0, exp_req});
                checkOutput("data",  {24'd0, data_out}, {24'd0, exp_data});
                checkOutput("done",  {31'd0, done}, {31'd0, exp_done});
                checkOutput("err",   {31'd0, err}, {31'd0, exp_err});
                checkOutput("ready", {31'd0, ready}, {31'd0, exp_ready});
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        n_rst   = 1'b0;
        send    = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req",   {31'd0, req_out}, 32'd0);
        checkOutput("rst_data",  {24'd0, data_out}, 32'd0);
        checkOutput("rst_done",  {31'd0, done}, 32'd0);
        checkOutput("rst_err",   {31'd0, err}, 32'd0);
        checkOutput("rst_ready", {31'd0, ready}, 32'd1);
        n_rst = 1'b1;

        // single transfer, then a send while busy that must be dropped
        remote_mode  = 0;
        remote_delay = 4;
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single_req",  {31'd0, req_out}, 32'd1);
        checkOutput("single_data", {24'd0, data_out}, 32'hA5);
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00);
        checkOutput("busy_data", {24'd0, data_out}, 32'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        checkOutput("single_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("single_done_pulse", {31'd0, done}, 32'd0);
        checkOutput("single_hold", {24'd0, data_out}, 32'hA5);
        checkOutput("busy_no_req", {31'd0, req_out}, 32'd0);
        waitReady("single_idle");

        // back-to-back: send held high across the first completion
        remote_delay = 2;
        applyStimulus(1'b1, 8'h01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_out && n < 50);
        data_in = 8'h02;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        checkOutput("b2b_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("b2b_req",  {31'd0, req_out}, 32'd1);
        checkOutput("b2b_data", {24'd0, data_out}, 32'h02);
        send = 1'b0;
        waitReady("b2b_idle");

        // ack stuck high while idle blocks new transfers
        remote_mode = 1;
        repeat (4) applyStimulus(1'b0, 8'h00);
        repeat (6) applyStimulus(1'b1, 8'h55);
        checkOutput("stuck_ready", {31'd0, ready}, 32'd0);
        checkOutput("stuck_req",   {31'd0, req_out}, 32'd0);
        remote_delay = 1;
        remote_mode  = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_out && n < 50);
        checkOutput("stuck_start", {31'd0, req_out}, 32'd1);
        send = 1'b0;
        waitReady("stuck_idle");

        // randomized transfers with random remote latency and stray sends
        for (int t = 0; t < 40; t++) begin
            remote_delay = int'($urandom_range(1, 6));
            applyStimulus(1'b1, DW'($urandom));
            repeat ($urandom_range(0, 5)) applyStimulus(1'($urandom_range(0, 1)), DW'($urandom));
            applyStimulus(1'b0, DW'($urandom));
            waitReady("rand_idle");
        end

        // reset in the middle of a transfer
        remote_delay = 3;
        applyStimulus(1'b1, 8'h99);
        applyStimulus(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("midrst_req",   {31'd0, req_out}, 32'd0);
        checkOutput("midrst_data",  {24'd0, data_out}, 32'd0);
        checkOutput("midrst_done",  {31'd0, done}, 32'd0);
        checkOutput("midrst_err",   {31'd0, err}, 32'd0);
        checkOutput("midrst_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) applyStimulus(1'b0, 8'h00);
        waitReady("midrst_idle");

        // remote never acknowledges
        remote_mode = 2;
        applyStimulus(1'b1, 8'h77);
        applyStimulus(1'b0, 8'h00);
`ifdef CDC_TX_TIMEOUT_EN
        n = 1;
        while (req_out && n < 100) begin
            @(negedge clk);
            if (req_out) n++;
        end
        checkOutput("timeout_len", n, TIMEOUT);
        checkOutput("timeout_err", {31'd0, err}, 32'd1);
        remote_mode = 0;
        waitReady("timeout_idle");
`else
        repeat (200) @(negedge clk);
        checkOutput("noto_req", {31'd0, req_out}, 32'd1);
        checkOutput("noto_err", {31'd0, err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
